// File: rtl/seq_table_counter.sv
// Table-driven sequence counter: an index walks a writable value table in wrap,
// hold or ping-pong order and F presents the registered entry at that index.
module seq_table_counter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] F,
  output logic [ADDR_W-1:0] idx,
  output logic              last,
  output logic              done,
  output logic              evt
);

  localparam int MEM_AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] IDX_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1'b1);
  localparam logic [1:0]        MODE_HOLD = 2'b01;
  localparam logic [1:0]        MODE_PING = 2'b10;

  typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] f_r;
  logic [ADDR_W-1:0] idx_r;
  dir_t              dir_r;
  logic              last_r;
  logic              done_r;
  logic              evt_r;

  logic [ADDR_W-1:0] len_eff_s;
  logic [ADDR_W-1:0] nxt_idx_s;
  dir_t              nxt_dir_s;
  logic              nxt_done_s;
  logic              nxt_evt_s;
  logic              load_f_s;
  logic              wr_ok_s;

  assign len_eff_s = ({1'b0, len} >= DEPTH_W) ? LAST_IDX : len;
  assign wr_ok_s   = ({1'b0, wr_addr} < DEPTH_W);

  // Next index, direction and status for this edge (restart beats en).
  always_comb begin
    nxt_idx_s  = idx_r;
    nxt_dir_s  = dir_r;
    nxt_done_s = done_r;
    nxt_evt_s  = 1'b0;
    load_f_s   = 1'b0;
    if (restart) begin
      nxt_idx_s  = IDX_ZERO;
      nxt_dir_s  = DIR_UP;
      nxt_done_s = 1'b0;
      load_f_s   = 1'b1;
    end else if (en) begin
      load_f_s = 1'b1;
      if (idx_r > len_eff_s) begin
        // len shrank below the current index: resynchronise from the start
        nxt_idx_s  = IDX_ZERO;
        nxt_dir_s  = DIR_UP;
        nxt_done_s = 1'b0;
      end else begin
        case (mode)
          MODE_HOLD: begin
            nxt_dir_s = DIR_UP;
            if (done_r) begin
              load_f_s = 1'b0;
            end else if (idx_r < len_eff_s) begin
              nxt_idx_s = idx_r + IDX_ONE;
              if ((idx_r + IDX_ONE) == len_eff_s) begin
                nxt_done_s = 1'b1;
                nxt_evt_s  = 1'b1;
              end else begin
                nxt_done_s = 1'b0;
              end
            end else begin
              nxt_done_s = 1'b1;
              nxt_evt_s  = 1'b1;
            end
          end
          MODE_PING: begin
            nxt_done_s = 1'b0;
            if (len_eff_s == IDX_ZERO) begin
              nxt_idx_s = IDX_ZERO;
            end else if (dir_r == DIR_UP) begin
              if (idx_r < len_eff_s) begin
                nxt_idx_s = idx_r + IDX_ONE;
              end else begin
                nxt_idx_s = idx_r - IDX_ONE;
                nxt_dir_s = DIR_DOWN;
                nxt_evt_s = 1'b1;
              end
            end else begin
              if (idx_r > IDX_ZERO) begin
                nxt_idx_s = idx_r - IDX_ONE;
              end else begin
                nxt_idx_s = idx_r + IDX_ONE;
                nxt_dir_s = DIR_UP;
                nxt_evt_s = 1'b1;
              end
            end
          end
          default: begin
            nxt_dir_s  = DIR_UP;
            nxt_done_s = 1'b0;
            if (idx_r < len_eff_s) begin
              nxt_idx_s = idx_r + IDX_ONE;
            end else begin
              nxt_idx_s = IDX_ZERO;
              nxt_evt_s = 1'b1;
            end
          end
        endcase
      end
    end else begin
      load_f_s = 1'b0;
    end
  end

  // Value table: cleared on reset, written whenever the strobe hits a valid address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (wr_en && wr_ok_s) begin
      mem_r[wr_addr[MEM_AW-1:0]] <= wr_data;
    end else begin
      mem_r <= mem_r;
    end
  end

  // Sequencer state and registered outputs; F reads the pre-write table.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_r    <= {DATA_W{1'b0}};
      idx_r  <= IDX_ZERO;
      dir_r  <= DIR_UP;
      last_r <= (len_eff_s == IDX_ZERO);
      done_r <= 1'b0;
      evt_r  <= 1'b0;
    end else begin
      idx_r  <= nxt_idx_s;
      dir_r  <= nxt_dir_s;
      last_r <= (nxt_idx_s == len_eff_s);
      done_r <= nxt_done_s;
      evt_r  <= nxt_evt_s;
      if (load_f_s) begin
        f_r <= mem_r[nxt_idx_s[MEM_AW-1:0]];
      end else begin
        f_r <= f_r;
      end
    end
  end

  assign F    = f_r;
  assign idx  = idx_r;
  assign last = last_r;
  assign done = done_r;
  assign evt  = evt_r;

endmodule

// File: tb/tb_seq_table_counter.sv
// Directed testbench for seq_table_counter; ADDR_W is widened to 4 so len and
// wr_addr can exceed DEPTH and exercise clamping and ignored writes.
module tb_seq_table_counter;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 4;

  logic              clk;
  logic              rst;
  logic              en;
  logic              restart;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] len;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] F;
  logic [ADDR_W-1:0] idx;
  logic              last;
  logic              done;
  logic              evt;

  int n_cmp;
  int n_err;

  seq_table_counter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .en(en), .restart(restart), .mode(mode), .len(len),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .F(F), .idx(idx), .last(last), .done(done), .evt(evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    en = 1'b0;
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; restart = 1'b0; mode = 2'b00; len = 4'd4;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    tick();
    tick();
    n_cmp++; if (F !== 8'd0)    begin n_err++; $display("FAIL reset_F got=%0d exp=0", F); end
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    n_cmp++; if (last !== 1'b0) begin n_err++; $display("FAIL reset_last got=%0b exp=0", last); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", done); end
    n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL reset_evt got=%0b exp=0", evt); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [7:0] addrs [9] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
    logic [7:0] vals  [9] = '{8'd13, 8'd15, 8'd17, 8'd17, 8'd45, 8'd50, 8'd60, 8'd70, 8'd77};
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1; wr_addr = addrs[i][ADDR_W-1:0]; wr_data = vals[i];
      tick();
    end
    wr_en = 1'b0;
    n_cmp++; if (F !== 8'd0) begin n_err++; $display("FAIL write_no_fwd got=%0d exp=0", F); end
    do_restart();
    n_cmp++; if (F !== 8'd13)  begin n_err++; $display("FAIL restart_F got=%0d exp=13", F); end
    n_cmp++; if (idx !== 4'd0) begin n_err++; $display("FAIL restart_idx got=%0d exp=0", idx); end
  endtask

  task automatic test_wrap();
    logic [7:0] ef [7] = '{8'd15, 8'd17, 8'd17, 8'd45, 8'd13, 8'd15, 8'd17};
    logic [3:0] ei [7] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2};
    logic       ee [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       el [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (F !== ef[i])    begin n_err++; $display("FAIL wrap_F[%0d] got=%0d exp=%0d", i, F, ef[i]); end
      n_cmp++; if (idx !== ei[i])  begin n_err++; $display("FAIL wrap_idx[%0d] got=%0d exp=%0d", i, idx, ei[i]); end
      n_cmp++; if (evt !== ee[i])  begin n_err++; $display("FAIL wrap_evt[%0d] got=%0b exp=%0b", i, evt, ee[i]); end
      n_cmp++; if (last !== el[i]) begin n_err++; $display("FAIL wrap_last[%0d] got=%0b exp=%0b", i, last, el[i]); end
    end
    do_restart();
  endtask

  task automatic test_hold();
    logic [7:0] ef [6] = '{8'd15, 8'd17, 8'd17, 8'd45, 8'd45, 8'd45};
    logic       ed [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       ee [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    mode = 2'b01; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_cmp++; if (F !== ef[i])    begin n_err++; $display("FAIL hold_F[%0d] got=%0d exp=%0d", i, F, ef[i]); end
      n_cmp++; if (done !== ed[i]) begin n_err++; $display("FAIL hold_done[%0d] got=%0b exp=%0b", i, done, ed[i]); end
      n_cmp++; if (evt !== ee[i])  begin n_err++; $display("FAIL hold_evt[%0d] got=%0b exp=%0b", i, evt, ee[i]); end
    end
    do_restart();
    n_cmp++; if (F !== 8'd13)   begin n_err++; $display("FAIL hold_restart_F got=%0d exp=13", F); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL hold_restart_done got=%0b exp=0", done); end
  endtask

  task automatic test_pingpong();
    logic [3:0] ei [9] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
    logic       ee [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] tbl [5] = '{8'd13, 8'd15, 8'd17, 8'd17, 8'd45};
    mode = 2'b10; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      n_cmp++; if (idx !== ei[i])      begin n_err++; $display("FAIL pp_idx[%0d] got=%0d exp=%0d", i, idx, ei[i]); end
      n_cmp++; if (evt !== ee[i])      begin n_err++; $display("FAIL pp_evt[%0d] got=%0b exp=%0b", i, evt, ee[i]); end
      n_cmp++; if (F !== tbl[ei[i]])   begin n_err++; $display("FAIL pp_F[%0d] got=%0d exp=%0d", i, F, tbl[ei[i]]); end
    end
    do_restart();
  endtask

  task automatic test_en_toggle();
    logic       pat [3] = '{1'b1, 1'b0, 1'b1};
    logic [3:0] ei  [3] = '{4'd1, 4'd1, 4'd2};
    logic [7:0] ef  [3] = '{8'd15, 8'd15, 8'd17};
    mode = 2'b00;
    for (int i = 0; i < 3; i++) begin
      en = pat[i];
      tick();
      n_cmp++; if (idx !== ei[i]) begin n_err++; $display("FAIL tog_idx[%0d] got=%0d exp=%0d", i, idx, ei[i]); end
      n_cmp++; if (F !== ef[i])   begin n_err++; $display("FAIL tog_F[%0d] got=%0d exp=%0d", i, F, ef[i]); end
      n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL tog_evt[%0d] got=%0b exp=0", i, evt); end
    end
  endtask

  task automatic test_len_change();
    logic [7:0] ef [7] = '{8'd15, 8'd17, 8'd17, 8'd45, 8'd50, 8'd60, 8'd70};
    en = 1'b1;
    tick();
    tick();
    n_cmp++; if (idx !== 4'd4)  begin n_err++; $display("FAIL lc_pre_idx got=%0d exp=4", idx); end
    len = 4'd2;
    tick();
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL lc_oor_idx got=%0d exp=0", idx); end
    n_cmp++; if (F !== 8'd13)   begin n_err++; $display("FAIL lc_oor_F got=%0d exp=13", F); end
    n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL lc_oor_evt got=%0b exp=0", evt); end
    len = 4'd12;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (F !== ef[i]) begin n_err++; $display("FAIL lc_clamp_F[%0d] got=%0d exp=%0d", i, F, ef[i]); end
    end
    n_cmp++; if (last !== 1'b1) begin n_err++; $display("FAIL lc_clamp_last got=%0b exp=1", last); end
    tick();
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL lc_wrap_idx got=%0d exp=0", idx); end
    n_cmp++; if (evt !== 1'b1)  begin n_err++; $display("FAIL lc_wrap_evt got=%0b exp=1", evt); end
  endtask

  task automatic test_write_collision();
    len = 4'd4; en = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'd99;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (F !== 8'd15)  begin n_err++; $display("FAIL wc_old_F got=%0d exp=15", F); end
    for (int i = 0; i < 5; i++) tick();
    n_cmp++; if (idx !== 4'd1) begin n_err++; $display("FAIL wc_idx got=%0d exp=1", idx); end
    n_cmp++; if (F !== 8'd99)  begin n_err++; $display("FAIL wc_new_F got=%0d exp=99", F); end
    en = 1'b0; wr_en = 1'b1; wr_data = 8'd55;
    tick();
    wr_en = 1'b0;
    n_cmp++; if (F !== 8'd99)  begin n_err++; $display("FAIL wc_hold_F got=%0d exp=99", F); end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1; en = 1'b1; restart = 1'b1; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'd11;
    tick();
    rst = 1'b0; restart = 1'b0; wr_en = 1'b0;
    n_cmp++; if (F !== 8'd0)    begin n_err++; $display("FAIL rst_F got=%0d exp=0", F); end
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL rst_idx got=%0d exp=0", idx); end
    n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL rst_evt got=%0b exp=0", evt); end
    tick();
    n_cmp++; if (idx !== 4'd1)  begin n_err++; $display("FAIL rst_step_idx got=%0d exp=1", idx); end
    n_cmp++; if (F !== 8'd0)    begin n_err++; $display("FAIL rst_cleared_F got=%0d exp=0", F); end
    len = 4'd0;
    tick();
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL z_oor_idx got=%0d exp=0", idx); end
    n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL z_oor_evt got=%0b exp=0", evt); end
    n_cmp++; if (last !== 1'b1) begin n_err++; $display("FAIL z_last got=%0b exp=1", last); end
    tick();
    n_cmp++; if (evt !== 1'b1)  begin n_err++; $display("FAIL z_wrap_evt got=%0b exp=1", evt); end
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL z_wrap_idx got=%0d exp=0", idx); end
    mode = 2'b10;
    tick();
    n_cmp++; if (evt !== 1'b0)  begin n_err++; $display("FAIL z_pp_evt got=%0b exp=0", evt); end
    n_cmp++; if (idx !== 4'd0)  begin n_err++; $display("FAIL z_pp_idx got=%0d exp=0", idx); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_write();
    test_wrap();
    test_hold();
    test_pingpong();
    test_en_toggle();
    test_len_change();
    test_write_collision();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_table_counter.md
Name: seq_table_counter

Overview:
- Parametrised table-driven sequence counter. An index steps through a writable value table and the registered output F presents the entry at the current index.
- Generalises the fixed 5-entry reset-loaded sequencer:
  - runtime-writable table
  - programmable sequence length
  - step enable and restart
  - three stepping modes (wrap, hold, ping-pong)
  - end-of-sequence status
- Sits beside lab datapaths as a pattern/stimulus source or a simple microsequence generator.

Parameters:
- DATA_W, 8, width of each table entry and of F
- DEPTH, 8, number of table entries (2..256)
- ADDR_W, 3, index width; must satisfy 2**ADDR_W >= DEPTH

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- en  input  1  advance index by one step this cycle
- restart  input  1  return to index 0, direction up, clear done
- mode  input  2  00 wrap, 01 hold, 10 ping-pong, 11 treated as wrap
- len  input  ADDR_W  last valid index; values >= DEPTH clamp to DEPTH-1 (len_eff)
- wr_en  input  1  table write strobe
- wr_addr  input  ADDR_W  table write address; writes with wr_addr >= DEPTH are ignored
- wr_data  input  DATA_W  table write data
- F  output  DATA_W  registered table value at current index
- idx  output  ADDR_W  registered current index
- last  output  1  registered; 1 when idx == len_eff
- done  output  1  registered; hold mode has reached len_eff and stopped
- evt  output  1  registered one-cycle pulse on end-of-sequence event

Behaviour:
- Single clock domain. Reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset (rst=1 at edge):
  - all table entries <= 0
  - idx <= 0, direction <= up
  - F <= 0, last <= (len_eff==0), done <= 0, evt <= 0
  - rst overrides wr_en, restart and en.
- Table write:
  - When wr_en=1 and not rst, MEM[wr_addr] <= wr_data at the edge.
  - No write-to-read forwarding: F computed at the same edge uses the pre-write contents.
  - Writes are independent of stepping and may occur every cycle.
- Priority per edge: rst > restart > en.
- Restart:
  - idx <= 0, dir <= up, done <= 0, evt <= 0, F <= MEM[0] (pre-write contents).
- Advance (en=1, no restart). next index depends on mode:
  - wrap: idx < len_eff -> idx+1. idx == len_eff -> 0, with evt pulse.
  - hold:
    - idx < len_eff -> idx+1.
    - Reaching len_eff sets done=1 and pulses evt once.
    - While done=1, en has no effect (idx, F, evt hold; evt=0).
  - ping-pong:
    - dir up: idx < len_eff -> idx+1. At len_eff -> dir<=down, idx-1, evt pulse.
    - dir down: idx > 0 -> idx-1. At 0 -> dir<=up, idx+1, evt pulse.
    - len_eff == 0: idx stays 0; no evt.
  - Out-of-range: if idx > len_eff when advancing (len reduced mid-run), then idx <= 0, dir <= up, done <= 0, evt <= 0 in every mode.
  - In wrap mode, len_eff == 0: idx stays 0 and evt pulses every enabled cycle.
- F update:
  - F <= MEM[next idx] on every advance or restart edge.
  - When idx is unchanged (en=0, or hold with done=1), F holds; table writes to the current idx do not update F until the next advance or restart.
- Latency: en high at edge N -> idx and F show the new entry after edge N (one cycle).
- last is recomputed from the new idx and the current len_eff at every edge.
- done clears only on rst, restart, an out-of-range advance, or a mode change away from hold at the next advance edge.
- evt is high for exactly the cycle following the triggering edge; it is 0 whenever en=0.
- Mode change takes effect at the next advance; dir persists across modes and is forced up when entering wrap or hold.
- Arithmetic: index math is unsigned ADDR_W-bit and never under- or overflows, given the rules above.

Test Plan:
- Reset, then write 13,15,17,17,45 to addresses 0..4; set len=4, mode=00, en=1 continuously -> F = 13,15,17,17,45,13,15,...; evt high in the cycle F returns to 13; last high while F=45.
- Same table, mode=01 -> F = 13,15,17,17,45 then holds 45 with done=1; evt pulses once; continued en leaves F=45; restart -> F=13, done=0.
- Same table, mode=10 -> idx 0,1,2,3,4,3,2,1,0,1; evt in the cycles after turnarounds at idx 4 and idx 0.
- Toggle en as 1,0,1 -> idx steps only on the enabled edges; F stable while en=0, evt=0.
- At idx=4, change len to 2 and advance -> idx=0, F=13; set len=12 with DEPTH=8 -> wrap occurs after idx 7.
- At the same edge: wr_en writes 99 to address 1 and en steps idx 0->1 -> F=15 (old value). After one further full cycle back to idx 1 -> F=99. rst asserted mid-run clears the table, F=0 and idx=0 on the next edge.
